// File: rtl/rr_arbiter_pkg.sv
// rtl/rr_arbiter_pkg.sv - shared types, sizes and rotating-priority search for rr_arbiter_4_1
package rr_arbiter_pkg;

   localparam int N_CH = 4;
   localparam int W    = 4;

   typedef logic [1:0] ch_idx_t;

   // Offsets are scanned from farthest to nearest, so the nearest valid channel at or after ptr is the last one written.
   function automatic ch_idx_t rr_pick(input logic [N_CH-1:0] valid, input ch_idx_t ptr);
      ch_idx_t idx;
      rr_pick = ptr;
      for (int k = N_CH - 1; k >= 0; k--) begin
         idx = ptr + ch_idx_t'(k);
         if (valid[idx]) rr_pick = idx;
      end
   endfunction

endpackage

// File: rtl/mux_4_1.sv
// rtl/mux_4_1.sv - combinational 4:1 data selector
module mux_4_1
   import rr_arbiter_pkg::*;
(
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   input  logic [W-1:0] d2,
   input  logic [W-1:0] d3,
   input  ch_idx_t      sel,
   output logic [W-1:0] y
);

   always_comb begin
      y = d0;
      unique case (sel)
         2'd0: y = d0;
         2'd1: y = d1;
         2'd2: y = d2;
         2'd3: y = d3;
      endcase
   end

endmodule

// File: rtl/rr_arbiter_4_1.sv
// rtl/rr_arbiter_4_1.sv - four-channel round-robin arbiter with a one-entry registered output
module rr_arbiter_4_1
   import rr_arbiter_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [N_CH-1:0]     in_valid,
   input  logic [W-1:0]        in_data0,
   input  logic [W-1:0]        in_data1,
   input  logic [W-1:0]        in_data2,
   input  logic [W-1:0]        in_data3,
   output logic [N_CH-1:0]     in_ready,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [W-1:0]        out_data,
   output ch_idx_t             out_sel
);

   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_data_q, out_data_d;
   ch_idx_t      out_sel_q, out_sel_d;
   ch_idx_t      ptr_q, ptr_d;
   ch_idx_t      grant;
   logic         space, any, accept;
   logic [W-1:0] mux_y;

   mux_4_1 u_mux (
      .d0  (in_data0),
      .d1  (in_data1),
      .d2  (in_data2),
      .d3  (in_data3),
      .sel (grant),
      .y   (mux_y)
   );

   // Reset gates accept so no source sees a handshake that the register will discard.
   always_comb begin
      space    = !out_valid_q || out_ready;
      any      = |in_valid;
      grant    = rr_pick(in_valid, ptr_q);
      accept   = space && any && !rst;
      in_ready = '0;
      if (accept) in_ready[grant] = 1'b1;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = mux_y;
         out_sel_d   = grant;
         ptr_d       = grant + 2'd1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arbiter_4_1.sv
// tb/tb_rr_arbiter_4_1.sv - self-checking bench for rr_arbiter_4_1
module tb_rr_arbiter_4_1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] in_valid = 4'b0;
   logic [3:0] in_data0 = 4'h0, in_data1 = 4'h0, in_data2 = 4'h0, in_data3 = 4'h0;
   logic [3:0] in_ready;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_data;
   logic [1:0] out_sel;

   int checks = 0;
   int errors = 0;

   // reference state: priority pointer and output register contents
   int m_ptr = 0;
   int m_ov  = 0;
   int m_od  = 0;
   int m_os  = 0;

   always #5 clk = ~clk;

   rr_arbiter_4_1 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data0  (in_data0),
      .in_data1  (in_data1),
      .in_data2  (in_data2),
      .in_data3  (in_data3),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // One cycle: drive at the falling edge, check against the model, then advance the model.
   task automatic step(input logic r, input logic [3:0] v, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d, input logic ordy, output int acc_ch);
      int dat[4];
      int g;
      int exp_rdy;
      @(negedge clk);
      rst = r; in_valid = v; out_ready = ordy;
      in_data0 = a; in_data1 = b; in_data2 = c; in_data3 = d;
      dat[0] = int'(a); dat[1] = int'(b); dat[2] = int'(c); dat[3] = int'(d);
      #1;
      g = -1;
      for (int k = 0; k < 4; k++)
         if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      acc_ch = -1;
      if (!r && (m_ov == 0 || ordy) && g >= 0) acc_ch = g;
      exp_rdy = (acc_ch >= 0) ? (1 << acc_ch) : 0;
      check("in_ready", int'(in_ready), exp_rdy);
      check("out_valid", int'(out_valid), m_ov);
      check("out_data", int'(out_data), m_od);
      check("out_sel", int'(out_sel), m_os);
      if (r) begin
         m_ptr = 0; m_ov = 0; m_od = 0; m_os = 0;
      end else if (acc_ch >= 0) begin
         m_ov = 1; m_od = dat[acc_ch]; m_os = acc_ch; m_ptr = (acc_ch + 1) % 4;
      end else if (m_ov == 1 && ordy) begin
         m_ov = 0;
      end
   endtask

   task automatic peek_sel(input string tag, input int exp_sel, input int exp_data);
      @(posedge clk);
      #1;
      check({tag, "_valid"}, int'(out_valid), 1);
      check({tag, "_sel"}, int'(out_sel), exp_sel);
      check({tag, "_data"}, int'(out_data), exp_data);
   endtask

   initial begin
      int acc;
      logic [3:0] pv;
      logic [3:0] pd[4];
      logic       r;
      logic       ordy;

      // reset then idle
      step(1'b1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, acc);
      step(1'b1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, acc);
      step(1'b0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, acc);

      // single channel
      step(1'b0, 4'b0100, 4'h0, 4'h0, 4'hA, 4'h0, 1'b1, acc);
      check("single_ready", int'(in_ready), 4);
      peek_sel("single", 2, 10);

      // full rotation from ptr=3: consume one grant of 3 first so the rotation starts at 0
      step(1'b0, 4'b1000, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, acc);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, acc);
         peek_sel("rot", i % 4, (i % 4) + 1);
      end

      // backpressure with out_data=3 held
      step(1'b0, 4'b0100, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, acc);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, acc);
         check("bp_ready", int'(in_ready), 0);
         check("bp_data", int'(out_data), 3);
      end
      step(1'b0, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, acc);
      peek_sel("bp_release", 3, 4);

      // pointer skip and wrap
      step(1'b0, 4'b1010, 4'h5, 4'h6, 4'h7, 4'h8, 1'b1, acc);
      peek_sel("skip1", 1, 6);
      step(1'b0, 4'b1010, 4'h5, 4'h6, 4'h7, 4'h8, 1'b1, acc);
      peek_sel("skip3", 3, 8);
      step(1'b0, 4'b1010, 4'h5, 4'h6, 4'h7, 4'h8, 1'b1, acc);
      peek_sel("wrap1", 1, 6);

      // reset mid-operation (ptr=2, out_valid=1)
      step(1'b1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, acc);
      check("rst_ready", int'(in_ready), 0);
      step(1'b0, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, acc);
      check("after_rst_valid_was", 0, m_ov == 1 && m_os == 0 ? 0 : 1);
      peek_sel("after_rst", 0, 1);

      // randomized traffic honouring the hold-until-ready rule
      pv = 4'b0;
      for (int c = 0; c < 4; c++) pd[c] = 4'h0;
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < 4; c++)
            if (!pv[c] && ($urandom_range(0, 1) == 1)) begin
               pv[c] = 1'b1;
               pd[c] = 4'($urandom_range(0, 15));
            end
         r    = ($urandom_range(0, 63) == 0);
         ordy = ($urandom_range(0, 3) != 0);
         step(r, pv, pd[0], pd[1], pd[2], pd[3], ordy, acc);
         if (acc >= 0) pv[acc] = 1'b0;
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_4_1.md
# rr_arbiter_4_1

Four-channel round-robin arbiter with a one-entry registered output, sitting directly upstream of the selection path. Each cycle it picks one of four valid/ready input channels fairly and computes the 2-bit select index, steers that channel's 4-bit data through a `mux_4_1` instance, and registers the result toward a single valid/ready consumer. It turns the combinational 4:1 mux into a flow-controlled, fair, one-cycle-latency stage.

## Interface

Parameters:
- None. Data width is fixed at 4 bits to match `mux_4_1`.

Ports:
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous reset, active-high
- `in_valid`  input  4  per-channel valid; bit i belongs to channel i
- `in_data0` .. `in_data3`  input  4 each  channel payloads
- `in_ready`  output  4  per-channel ready; at most one bit high (one-hot or zero)
- `out_valid`  output  1  output register holds an item
- `out_ready`  input  1  consumer accepts when high together with `out_valid`
- `out_data`  output  4  registered payload
- `out_sel`  output  2  registered index of the channel that supplied `out_data`

## Operation

- State: round-robin pointer `ptr[1:0]` (highest-priority channel) and a one-entry output register (`out_valid`, `out_data`, `out_sel`).
- `space` = `!out_valid || out_ready`. This means the register is empty or is drained this cycle.
- Grant search: scan channels `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4). `grant` is the first channel with `in_valid` high. `any` = `|in_valid`.
- `accept` = `space && any`. `in_ready[grant]` = `accept`; all other `in_ready` bits are 0. When `accept` is 0, all `in_ready` bits are 0.
- On `accept`:
  - `out_data` <= `mux_4_1` output with `sel = grant`.
  - `out_sel` <= `grant`, `out_valid` <= 1.
  - `ptr` <= `grant + 1` (2-bit wrap, so 3 -> 0).
- Drain with no accept (`out_valid && out_ready && !any`): `out_valid` <= 0. `out_data` and `out_sel` hold.
- No `space`: register and `ptr` hold. `out_data` and `out_sel` stay stable while `out_valid && !out_ready`.
- `ptr` changes only on `accept`. Idle cycles never move priority.
- Implicit states:
  - EMPTY (`out_valid` = 0) goes to FULL on `accept`.
  - FULL with `out_ready` goes to FULL on `accept`, or to EMPTY otherwise.
  - FULL without `out_ready` stays FULL.
- Input protocol: a source must hold `in_valid` and its data until it sees `in_ready`. `in_ready` may depend combinationally on `in_valid` and `out_ready`.

## Timing

- Reset values: `out_valid` = 0, `out_data` = 4'h0, `out_sel` = 2'd0, `ptr` = 2'd0, `in_ready` = 4'b0000 during reset.
- Reset has priority over every other event. An item held mid-operation is discarded, with no drain.
- Latency: an input handshake in cycle N gives `out_valid` with that data in cycle N+1.
- Throughput: one item per cycle when `out_ready` is held high, including a drain and a refill in the same cycle.
- Fairness: with all four channels continuously valid, grants are strictly 0,1,2,3,0,… Any continuously valid channel is served within 4 accepts.
- Combinational paths:
  - `in_valid` -> `in_ready`
  - `out_ready` -> `in_ready`
- No combinational path from any input to `out_valid`, `out_data` or `out_sel`.

## Structure

- Shared package `rr_arbiter_pkg`:
  - `localparam N_CH = 4`
  - `localparam W = 4`
  - `typedef logic [1:0] ch_idx_t`
  - `function ch_idx_t rr_pick(logic [3:0] valid, ch_idx_t ptr)` for the rotating priority search
- Sub-module: exactly one `mux_4_1` instance for the data path, with `d0`..`d3` = `in_data0`..`in_data3` and `sel = grant`.
- Grant logic, pointer and output register are local `always_comb` / `always_ff` logic.

## Test plan

- Reset then idle: `rst` for 2 cycles, `in_valid` = 0 -> `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `in_ready` = 0000 throughout.
- Single channel: `in_valid` = 0100, `in_data2` = 4'hA, `out_ready` = 1 -> `in_ready` = 0100, next cycle `out_valid` = 1, `out_data` = A, `out_sel` = 2.
- Full rotation: `in_valid` = 1111 with data 1,2,3,4 for channels 0–3, `out_ready` = 1 for 8 cycles -> `out_sel` sequence 0,1,2,3,0,1,2,3 and `out_data` 1,2,3,4,1,2,3,4.
- Backpressure: register full with `out_data` = 3, `out_ready` = 0 for 5 cycles, `in_valid` = 1111 -> `in_ready` = 0000 and outputs stable. `out_ready` = 1 -> next grant follows the stored `ptr`.
- Pointer skip and wrap: after a grant of channel 3 (`ptr` = 0), set `in_valid` = 1010 -> grant 1, then grant 3, then grant 1.
- Reset mid-operation: `out_valid` = 1 with `ptr` = 2, assert `rst` 1 cycle -> `out_valid` = 0 next cycle and `ptr` = 0. `in_valid` = 1111 then grants channel 0 first.
